// File: rtl/axi4_b_err_merger.sv
// Merges forwarded AXI4 B responses with locally generated SLVERR responses
// for dropped write bursts, behind a single registered output slot.
module axi4_b_err_merger #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 4,
    parameter int ERR_DEPTH      = 4
) (
    input  logic                          axi4_aclk,
    input  logic                          axi4_arst,
    input  logic                          drop_valid,
    input  logic [AXI_ID_WIDTH-1:0]       drop_id,
    input  logic [AXI_USER_WIDTH-1:0]     drop_user,
    output logic                          drop_ready,
    input  logic                          wdone,
    input  logic [AXI_ID_WIDTH-1:0]       m_axi4_bid,
    input  logic [1:0]                    m_axi4_bresp,
    input  logic [AXI_USER_WIDTH-1:0]     m_axi4_buser,
    input  logic                          m_axi4_bvalid,
    output logic                          m_axi4_bready,
    output logic [AXI_ID_WIDTH-1:0]       s_axi4_bid,
    output logic [1:0]                    s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0]     s_axi4_buser,
    output logic                          s_axi4_bvalid,
    input  logic                          s_axi4_bready,
    output logic [$clog2(ERR_DEPTH):0]    err_pending
);

    localparam int PW = $clog2(ERR_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(ERR_DEPTH);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [AXI_ID_WIDTH-1:0]   r_mem_id   [ERR_DEPTH];
    logic [AXI_USER_WIDTH-1:0] r_mem_user [ERR_DEPTH];
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [CW-1:0]             r_count;
    logic [CW-1:0]             r_done;
    logic                      r_last_err;
    logic                      r_bvalid;
    logic [AXI_ID_WIDTH-1:0]   r_bid;
    logic [1:0]                r_bresp;
    logic [AXI_USER_WIDTH-1:0] r_buser;

    logic w_slot_free;
    logic w_err_elig;
    logic w_gnt_err;
    logic w_gnt_fwd;
    logic w_push;
    logic w_pop;
    logic w_wdone_inc;

    assign w_slot_free = !r_bvalid || s_axi4_bready;
    assign w_err_elig  = (r_done != '0);

    // On a tie, r_last_err picks whichever source lost the previous load.
    assign w_gnt_err = w_slot_free && w_err_elig
                       && (!m_axi4_bvalid || !r_last_err);
    assign w_gnt_fwd = w_slot_free && m_axi4_bvalid
                       && (!w_err_elig || r_last_err);

    assign drop_ready    = (r_count < DEPTH_C) && !axi4_arst;
    assign m_axi4_bready = w_gnt_fwd && !axi4_arst;

    assign w_push      = drop_valid && drop_ready;
    assign w_pop       = w_gnt_err;
    assign w_wdone_inc = wdone && (r_done < r_count);

    always_ff @(posedge axi4_aclk) begin
        if (w_push) begin
            r_mem_id[r_wptr]   <= drop_id;
            r_mem_user[r_wptr] <= drop_user;
        end
    end

    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_done     <= '0;
            r_last_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_done  <= r_done + CW'(w_wdone_inc) - CW'(w_pop);
            if (w_gnt_err) begin
                r_last_err <= 1'b1;
            end else if (w_gnt_fwd) begin
                r_last_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= '0;
            r_buser  <= '0;
        end else if (w_slot_free) begin
            r_bvalid <= w_gnt_err || w_gnt_fwd;
            if (w_gnt_err) begin
                r_bid   <= r_mem_id[r_rptr];
                r_bresp <= RESP_SLVERR;
                r_buser <= r_mem_user[r_rptr];
            end else if (w_gnt_fwd) begin
                r_bid   <= m_axi4_bid;
                r_bresp <= m_axi4_bresp;
                r_buser <= m_axi4_buser;
            end
        end
    end

    assign s_axi4_bvalid = r_bvalid;
    assign s_axi4_bid    = r_bid;
    assign s_axi4_bresp  = r_bresp;
    assign s_axi4_buser  = r_buser;
    assign err_pending   = r_count;

endmodule

// File: tb/tb_axi4_b_err_merger.sv
// Directed bench for axi4_b_err_merger: forwarding, error injection,
// queue full handling, arbitration, backpressure and async reset.
module tb_axi4_b_err_merger;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drop_valid = 1'b0;
    logic [3:0] drop_id = '0;
    logic [3:0] drop_user = '0;
    logic       drop_ready;
    logic       wdone = 1'b0;
    logic [3:0] m_bid = '0;
    logic [1:0] m_bresp = '0;
    logic [3:0] m_buser = '0;
    logic       m_bvalid = 1'b0;
    logic       m_bready;
    logic [3:0] s_bid;
    logic [1:0] s_bresp;
    logic [3:0] s_buser;
    logic       s_bvalid;
    logic       s_bready = 1'b0;
    logic [2:0] err_pending;

    int n_chk = 0;
    int n_pass = 0;

    axi4_b_err_merger #(
        .AXI_ID_WIDTH(4),
        .AXI_USER_WIDTH(4),
        .ERR_DEPTH(4)
    ) dut (
        .axi4_aclk(clk),
        .axi4_arst(rst),
        .drop_valid(drop_valid),
        .drop_id(drop_id),
        .drop_user(drop_user),
        .drop_ready(drop_ready),
        .wdone(wdone),
        .m_axi4_bid(m_bid),
        .m_axi4_bresp(m_bresp),
        .m_axi4_buser(m_buser),
        .m_axi4_bvalid(m_bvalid),
        .m_axi4_bready(m_bready),
        .s_axi4_bid(s_bid),
        .s_axi4_bresp(s_bresp),
        .s_axi4_buser(s_buser),
        .s_axi4_bvalid(s_bvalid),
        .s_axi4_bready(s_bready),
        .err_pending(err_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] id,
                            input logic [1:0] resp, input logic [3:0] user);
        chk({tag, "_v"}, 32'(s_bvalid), 32'd1);
        chk({tag, "_id"}, 32'(s_bid), 32'(id));
        chk({tag, "_resp"}, 32'(s_bresp), 32'(resp));
        chk({tag, "_user"}, 32'(s_buser), 32'(user));
    endtask

    task automatic push(input logic [3:0] id, input logic [3:0] user);
        drop_valid = 1'b1;
        drop_id    = id;
        drop_user  = user;
        tick();
        drop_valid = 1'b0;
    endtask

    initial begin
        // reset state, ready outputs forced low
        m_bvalid = 1'b1;
        drop_valid = 1'b1;
        tick();
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_dready", 32'(drop_ready), 32'd0);
        chk("rst_mready", 32'(m_bready), 32'd0);
        m_bvalid = 1'b0;
        drop_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_bvalid", 32'(s_bvalid), 32'd0);
        chk("idle_bid", 32'(s_bid), 32'd0);
        chk("idle_bresp", 32'(s_bresp), 32'd0);
        chk("idle_buser", 32'(s_buser), 32'd0);
        chk("idle_pend", 32'(err_pending), 32'd0);
        chk("idle_dready", 32'(drop_ready), 32'd1);
        chk("idle_mready", 32'(m_bready), 32'd0);

        // forward only, back to back
        s_bready = 1'b1;
        m_bvalid = 1'b1;
        m_bid = 4'd3; m_bresp = 2'b00; m_buser = 4'd1;
        #1 chk("fwd_mready0", 32'(m_bready), 32'd1);
        tick();
        chk_beat("fwd0", 4'd3, 2'b00, 4'd1);
        m_bid = 4'd5; m_bresp = 2'b01; m_buser = 4'd6;
        #1 chk("fwd_mready1", 32'(m_bready), 32'd1);
        tick();
        chk_beat("fwd1", 4'd5, 2'b01, 4'd6);
        m_bvalid = 1'b0;
        tick();
        chk("fwd_end", 32'(s_bvalid), 32'd0);

        // single drop
        push(4'd7, 4'd2);
        chk("sd_pend1", 32'(err_pending), 32'd1);
        chk("sd_noelig0", 32'(s_bvalid), 32'd0);
        tick();
        tick();
        chk("sd_noelig1", 32'(s_bvalid), 32'd0);
        wdone = 1'b1;
        tick();
        wdone = 1'b0;
        chk("sd_lat", 32'(s_bvalid), 32'd0);
        chk("sd_pend_hold", 32'(err_pending), 32'd1);
        tick();
        chk_beat("sd", 4'd7, 2'b10, 4'd2);
        chk("sd_pend0", 32'(err_pending), 32'd0);
        tick();
        chk("sd_end", 32'(s_bvalid), 32'd0);

        // fill to full, then over-pulse wdone
        for (int i = 0; i < 4; i++) begin
            push(4'(i + 1), 4'(i + 8));
        end
        chk("full_pend", 32'(err_pending), 32'd4);
        chk("full_dready", 32'(drop_ready), 32'd0);
        drop_valid = 1'b1; drop_id = 4'd9; drop_user = 4'd9;
        tick();
        drop_valid = 1'b0;
        chk("full_5th", 32'(err_pending), 32'd4);
        s_bready = 1'b0;
        wdone = 1'b1;
        tick();
        chk("full_w1_v", 32'(s_bvalid), 32'd0);
        tick();
        chk_beat("full_h1", 4'd1, 2'b10, 4'd8);
        chk("full_pend3", 32'(err_pending), 32'd3);
        for (int i = 0; i < 4; i++) tick();
        wdone = 1'b0;
        chk_beat("full_hold", 4'd1, 2'b10, 4'd8);
        chk("full_pend3b", 32'(err_pending), 32'd3);
        s_bready = 1'b1;
        tick();
        chk_beat("full_d2", 4'd2, 2'b10, 4'd9);
        tick();
        chk_beat("full_d3", 4'd3, 2'b10, 4'd10);
        tick();
        chk_beat("full_d4", 4'd4, 2'b10, 4'd11);
        chk("full_pend0", 32'(err_pending), 32'd0);
        tick();
        chk("full_drained", 32'(s_bvalid), 32'd0);
        // excess wdone must not leave stray credit
        push(4'd6, 4'd3);
        tick();
        chk("credit_none0", 32'(s_bvalid), 32'd0);
        tick();
        chk("credit_none1", 32'(s_bvalid), 32'd0);
        wdone = 1'b1;
        tick();
        wdone = 1'b0;
        tick();
        chk_beat("credit_ok", 4'd6, 2'b10, 4'd3);
        tick();

        // async reset with held beat and queued entry
        s_bready = 1'b0;
        m_bvalid = 1'b1; m_bid = 4'd4; m_bresp = 2'b11; m_buser = 4'd4;
        drop_valid = 1'b1; drop_id = 4'd8; drop_user = 4'd8;
        tick();
        m_bvalid = 1'b0;
        drop_valid = 1'b0;
        chk_beat("pre_rst", 4'd4, 2'b11, 4'd4);
        chk("pre_rst_pend", 32'(err_pending), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_bvalid", 32'(s_bvalid), 32'd0);
        chk("arst_pend", 32'(err_pending), 32'd0);
        chk("arst_bid", 32'(s_bid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_v", 32'(s_bvalid), 32'd0);

        // contention: err, fwd, err, fwd
        s_bready = 1'b1;
        push(4'd10, 4'd1);
        push(4'd11, 4'd2);
        wdone = 1'b1;
        tick();
        m_bvalid = 1'b1; m_bid = 4'd12; m_bresp = 2'b00; m_buser = 4'd5;
        #1 chk("ct_mready0", 32'(m_bready), 32'd0);
        tick();
        wdone = 1'b0;
        chk_beat("ct0", 4'd10, 2'b10, 4'd1);
        chk("ct_mready1", 32'(m_bready), 32'd1);
        tick();
        chk_beat("ct1", 4'd12, 2'b00, 4'd5);
        m_bid = 4'd13; m_bresp = 2'b01; m_buser = 4'd6;
        #1 chk("ct_mready2", 32'(m_bready), 32'd0);
        tick();
        chk_beat("ct2", 4'd11, 2'b10, 4'd2);
        tick();
        chk_beat("ct3", 4'd13, 2'b01, 4'd6);
        m_bvalid = 1'b0;
        tick();
        chk("ct_end", 32'(s_bvalid), 32'd0);

        // backpressure with both sources pending
        push(4'd2, 4'd5);
        push(4'd3, 4'd7);
        s_bready = 1'b0;
        wdone = 1'b1;
        tick();
        tick();
        wdone = 1'b0;
        chk_beat("bp_first", 4'd2, 2'b10, 4'd5);
        m_bvalid = 1'b1; m_bid = 4'd9; m_bresp = 2'b01; m_buser = 4'd4;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_mready", 32'(m_bready), 32'd0);
            tick();
            chk_beat("bp_hold", 4'd2, 2'b10, 4'd5);
            chk("bp_pend", 32'(err_pending), 32'd1);
        end
        s_bready = 1'b1;
        #1 chk("bp_rel_mready", 32'(m_bready), 32'd1);
        tick();
        m_bvalid = 1'b0;
        chk_beat("bp_d0", 4'd9, 2'b01, 4'd4);
        tick();
        chk_beat("bp_d1", 4'd3, 2'b10, 4'd7);
        chk("bp_pend0", 32'(err_pending), 32'd0);
        tick();
        chk("bp_end", 32'(s_bvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
